exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have exactly one clock domain and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port resetn, input, 1 bit: reset; asynchronous and active-high (1 = reset asserted), despite the codebase port name.
REQ-004 Port instr_done_i, input, 1 bit: the current instruction has completed; this is the only sampling point.
REQ-005 Inputs pc_i and next_pc_i, 32 bits each: PC of the completing instruction and its successor.
REQ-006 Inputs exc_ri_i, exc_ov_i, exc_sys_i and eret_i, 1 bit each: reserved instruction, overflow, syscall and ERET flags; all are qualified by instr_done_i.
REQ-007 Inputs status_i, cause_i and epc_i, 32 bits each, plus timer_int_i, 1 bit: live values read from CP0.
REQ-008 Outputs cp0_we_o (1 bit), cp0_waddr_o (5 bits) and cp0_wdata_o (32 bits): the CP0 write port; at most one write per cycle.
REQ-009 Outputs pc_we_o (1 bit) and new_pc_o (32 bits): PC redirect; pc_we_o is a one-cycle pulse.
REQ-010 Output exccode_o, 5 bits: ExcCode of the last exception taken; held until the next exception.
REQ-011 Output busy_o, 1 bit: high in every state except IDLE; the core SHALL stall its fetch while busy_o is high.

Function
REQ-012 The states SHALL be IDLE, SAVE_EPC, SET_EXL, CLR_EXL and REDIRECT.
REQ-013 Events SHALL be evaluated only in IDLE with instr_done_i=1; events raised while busy_o=1 are ignored.
REQ-014 Event priority SHALL be eret_i > exc_ri_i > exc_ov_i > exc_sys_i > interrupt.
REQ-015 Interrupt pending SHALL be: status_i[0]=1 AND status_i[1]=0 AND ((cause_i[15:8] | {timer_int_i,7'b0}) & status_i[15:8]) != 0.
REQ-016 ExcCode values SHALL be: Int=0, Sys=8, RI=10, Ov=12; exccode_o is latched when an exception is accepted.
REQ-017 For a synchronous exception, the saved PC SHALL be pc_i; for an interrupt it SHALL be next_pc_i; the saved PC is latched on accept.
REQ-018 On exception accept, the FSM SHALL go to SAVE_EPC if status_i[1]=0, else skip to SET_EXL, leaving EPC untouched.
REQ-019 In SAVE_EPC the block SHALL drive we=1, waddr=14, wdata=saved PC, then go to SET_EXL.
REQ-020 In SET_EXL the block SHALL drive we=1, waddr=12, wdata=status_i|32'h2, latch new_pc = (status_i[22] ? 32'hBFC00380 : 32'h80000180), then go to REDIRECT.
REQ-021 On ERET accept, the block SHALL latch new_pc=epc_i and go to CLR_EXL.
REQ-022 In CLR_EXL the block SHALL drive we=1, waddr=12, wdata=status_i&~32'h2, then go to REDIRECT.
REQ-023 In REDIRECT the block SHALL drive pc_we_o=1 for exactly one cycle, then return to IDLE.
REQ-024 Latency from accept edge to pc_we_o SHALL be: exception with EXL=0, 3 cycles; with EXL=1, 2 cycles; ERET, 2 cycles.
REQ-025 The CP0 write outputs (cp0_we_o, cp0_waddr_o, cp0_wdata_o) SHALL be combinational from state and registers; in all states other than SAVE_EPC, SET_EXL and CLR_EXL, cp0_we_o=0 and cp0_waddr_o/cp0_wdata_o=0.
REQ-026 An interrupt and a synchronous exception arriving in the same cycle SHALL take the synchronous exception only; the interrupt is re-evaluated at the next instr_done_i.

Reset
REQ-027 Reset SHALL force: state=IDLE, busy_o=0, cp0_we_o=0, pc_we_o=0, new_pc_o=0, exccode_o=0, saved PC=0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately, with no further CP0 write or redirect after release.

Structure
REQ-029 A shared package SHALL hold: state encoding; CP0 register addresses (STATUS=12, CAUSE=13, EPC=14); ExcCode constants; both vector addresses; status bit indices (IE=0, EXL=1, BEV=22).
REQ-030 The design SHALL be one flat module; an optional combinational sub-module exc_prio SHALL compute the selected event and ExcCode.

Verification
REQ-031 RI with status=0x10000000, pc_i=0x00400010 -> EPC write of 0x00400010, then status write 0x10000002, then pc_we_o with 0x80000180, exccode_o=10.
REQ-032 timer_int_i=1, status=0x10008001, next_pc_i=0x00400024 -> EPC=0x00400024, exccode_o=0, redirect to 0x80000180 on the 3rd cycle after accept.
REQ-033 ERET with status=0x10000003, epc_i=0x00400024 -> status write 0x10000001, redirect to 0x00400024 2 cycles after accept.
REQ-034 SYS with status EXL=1 and BEV=1 (0x10400002) -> no EPC write, status write 0x10400002, redirect to 0xBFC00380.
REQ-035 Simultaneous exc_ov_i and enabled interrupt -> exccode_o=12, EPC=pc_i; a second instr_done_i while busy_o=1 is ignored.
REQ-036 Reset asserted during SET_EXL -> all outputs 0 asynchronously, and no pc_we_o after release.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/ERET sequencer: FSM states, event codes,
// CP0 register addresses, ExcCodes, vectors and status bit positions.
package exc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE_EPC = 3'd1,
        ST_SET_EXL  = 3'd2,
        ST_CLR_EXL  = 3'd3,
        ST_REDIRECT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_ERET = 3'd1,
        EV_RI   = 3'd2,
        EV_OV   = 3'd3,
        EV_SYS  = 3'd4,
        EV_INT  = 3'd5
    } event_e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;
    localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned ST_BEV = 22;

    localparam logic [31:0] EXL_MASK = 32'h0000_0002;

    // The timer line is folded into IP7 before masking with IM.
    function automatic logic int_pending(input logic       ie,
                                         input logic       exl,
                                         input logic [7:0] ip,
                                         input logic [7:0] im,
                                         input logic       timer);
        logic [7:0] ip_all;
        ip_all = ip | {timer, 7'b000_0000};
        return ie && !exl && ((ip_all & im) != 8'h00);
    endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational event selector: picks the highest-priority pending event and
// its ExcCode from the flags of the completing instruction.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic       eret_i,
    input  logic       exc_ri_i,
    input  logic       exc_ov_i,
    input  logic       exc_sys_i,
    input  logic       timer_int_i,
    input  logic       status_ie_i,
    input  logic       status_exl_i,
    input  logic [7:0] ip_i,
    input  logic [7:0] im_i,
    output event_e     event_o,
    output logic [4:0] exccode_o
);

    logic irq_s;

    assign irq_s = int_pending(status_ie_i, status_exl_i, ip_i, im_i, timer_int_i);

    // Fixed priority chain; synchronous exceptions shadow a same-cycle interrupt.
    always_comb begin
        event_o   = EV_NONE;
        exccode_o = EXC_INT;
        if (eret_i) begin
            event_o   = EV_ERET;
            exccode_o = EXC_INT;
        end else if (exc_ri_i) begin
            event_o   = EV_RI;
            exccode_o = EXC_RI;
        end else if (exc_ov_i) begin
            event_o   = EV_OV;
            exccode_o = EXC_OV;
        end else if (exc_sys_i) begin
            event_o   = EV_SYS;
            exccode_o = EXC_SYS;
        end else if (irq_s) begin
            event_o   = EV_INT;
            exccode_o = EXC_INT;
        end else begin
            event_o   = EV_NONE;
            exccode_o = EXC_INT;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ERET sequencer: samples events at instruction completion, performs
// the EPC and Status CP0 writes one per cycle, then redirects the PC.
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_done_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] next_pc_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_sys_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        pc_we_o,
    output logic [31:0] new_pc_o,
    output logic [4:0]  exccode_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        pc_we_q, pc_we_d;
    logic        busy_q, busy_d;

    event_e      ev_s;
    logic [4:0]  ev_code_s;
    logic        unused_cause_s;

    assign unused_cause_s = ^{cause_i[31:16], cause_i[7:0]};

    exc_prio u_prio (
        .eret_i       (eret_i),
        .exc_ri_i     (exc_ri_i),
        .exc_ov_i     (exc_ov_i),
        .exc_sys_i    (exc_sys_i),
        .timer_int_i  (timer_int_i),
        .status_ie_i  (status_i[ST_IE]),
        .status_exl_i (status_i[ST_EXL]),
        .ip_i         (cause_i[15:8]),
        .im_i         (status_i[15:8]),
        .event_o      (ev_s),
        .exccode_o    (ev_code_s)
    );

    // Next-state and datapath latching; events are only looked at from IDLE.
    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        new_pc_d   = new_pc_q;
        exccode_d  = exccode_q;
        pc_we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_done_i) begin
                    case (ev_s)
                        EV_NONE: begin
                            state_d = ST_IDLE;
                        end
                        EV_ERET: begin
                            new_pc_d = epc_i;
                            state_d  = ST_CLR_EXL;
                        end
                        default: begin
                            exccode_d  = ev_code_s;
                            saved_pc_d = (ev_s == EV_INT) ? next_pc_i : pc_i;
                            state_d    = status_i[ST_EXL] ? ST_SET_EXL : ST_SAVE_EPC;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE_EPC: begin
                state_d = ST_SET_EXL;
            end
            ST_SET_EXL: begin
                new_pc_d = status_i[ST_BEV] ? VEC_BOOT : VEC_NORMAL;
                pc_we_d  = 1'b1;
                state_d  = ST_REDIRECT;
            end
            ST_CLR_EXL: begin
                pc_we_d = 1'b1;
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= ST_IDLE;
            saved_pc_q <= 32'h0000_0000;
            new_pc_q   <= 32'h0000_0000;
            exccode_q  <= 5'd0;
            pc_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_pc_q <= saved_pc_d;
            new_pc_q   <= new_pc_d;
            exccode_q  <= exccode_d;
            pc_we_q    <= pc_we_d;
            busy_q     <= busy_d;
        end
    end

    // CP0 write port decoded from the current state; idle value is all zero.
    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = 5'd0;
        cp0_wdata_o = 32'h0000_0000;
        case (state_q)
            ST_SAVE_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_EPC;
                cp0_wdata_o = saved_pc_q;
            end
            ST_SET_EXL: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_STATUS;
                cp0_wdata_o = status_i | EXL_MASK;
            end
            ST_CLR_EXL: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_STATUS;
                cp0_wdata_o = status_i & ~EXL_MASK;
            end
            default: begin
                cp0_we_o    = 1'b0;
                cp0_waddr_o = 5'd0;
                cp0_wdata_o = 32'h0000_0000;
            end
        endcase
    end

    assign pc_we_o   = pc_we_q;
    assign new_pc_o  = new_pc_q;
    assign exccode_o = exccode_q;
    assign busy_o    = busy_q;

endmodule
